// File: rtl/reg_file.sv
// Register file in front of the 8-bit ALU: two combinational read ports and one synchronous write port.
// It also holds the registered zero flag that captures the ALU zero output.
module reg_file #(
    parameter int DW     = 8,
    parameter int AW     = 3,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rd_addrA,
    input  logic [AW-1:0] rd_addrB,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] dat_in,
    input  logic          flag_we,
    input  logic          zero_in,
    output logic          zero_flag
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic          zero_q;

    // Reset takes priority over any pending write or flag capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            zero_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= dat_in;
            end
            if (flag_we) begin
                zero_q <= zero_in;
            end
        end
    end

    assign zero_flag = zero_q;

    logic [DW-1:0] stored_a;
    logic [DW-1:0] stored_b;

    assign stored_a = mem[rd_addrA];
    assign stored_b = mem[rd_addrB];

    generate
        if (BYPASS != 0) begin : g_bypass
            logic fwd_a;
            logic fwd_b;

            // Forwarding is gated by reset so a discarded write never leaks onto a port.
            assign fwd_a = wr_en && !reset && (wr_addr == rd_addrA);
            assign fwd_b = wr_en && !reset && (wr_addr == rd_addrB);

            assign datA_out = fwd_a ? dat_in : stored_a;
            assign datB_out = fwd_b ? dat_in : stored_b;
        end else begin : g_no_bypass
            assign datA_out = stored_a;
            assign datB_out = stored_b;
        end
    endgenerate

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file that sits directly upstream of the 8-bit ALU.
- Supplies both ALU operands through two combinational read ports.
- Accepts the ALU result on a single synchronous write port.
- Holds the zero-flag register that captures the ALU zero output for branch decisions.

Parameters:
- DW, 8, data width in bits; matches the ALU datapath.
- AW, 3, address width; the file holds 2**AW registers.
- BYPASS, 1, 1 means a same-cycle write is forwarded to the read ports; 0 means reads return the stored value only.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- rd_addrA  input  AW  read address for port A (feeds ALU inA).
- rd_addrB  input  AW  read address for port B (feeds ALU inB).
- datA_out  output  DW  port A read data.
- datB_out  output  DW  port B read data.
- wr_en  input  1  register write enable.
- wr_addr  input  AW  write address.
- dat_in  input  DW  write data (ALU rslt or load data).
- flag_we  input  1  zero-flag capture enable.
- zero_in  input  1  zero indication from the ALU.
- zero_flag  output  1  registered zero flag.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset; there are no asynchronous paths to state.
- Reset:
  - On any rising edge with reset=1, all 2**AW registers clear to 0 and zero_flag clears to 0.
  - Reset overrides wr_en and flag_we in the same cycle.
  - A write pending in the reset cycle is discarded.
- Reads:
  - Combinational and zero-latency; each port is fully independent.
  - rd_addrA and rd_addrB may be equal; both ports then return identical data.
  - After reset, any read returns 0 (once the post-reset combinational settle completes).
- Writes:
  - On a rising edge with reset=0 and wr_en=1, mem[wr_addr] <= dat_in.
  - Data is visible on the read ports (stored path) from the cycle after the edge.
  - wr_en=0 leaves all registers unchanged.
  - Every address, including 0, is writable; there is no hardwired-zero register.
- Bypass:
  - BYPASS=1: when wr_en=1, reset=0 and wr_addr equals a read address, that port outputs dat_in combinationally in the same cycle.
  - The forward applies to each port independently, and to both ports if both match.
  - BYPASS=0: the port shows the old stored value until the edge.
  - Bypass is suppressed while reset=1; outputs then show stored values.
- Zero flag:
  - On a rising edge with reset=0 and flag_we=1, zero_flag <= zero_in.
  - Otherwise zero_flag holds its value.
  - Flag capture and register write are independent; both may occur on the same edge.
  - The flag is not derived from dat_in; it always comes from zero_in.
- Widths:
  - No arithmetic is performed; dat_in is stored as-is.
  - Addresses are AW bits, so there is no out-of-range case.
- Unknowns: X on wr_addr while wr_en=1 is a bench error. The bench flags it with a simulation assertion; it is not a functional requirement.
- No display or print statements in synthesizable paths; the bench owns all logging.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with wr_en=1, wr_addr=3, dat_in=8'hAA, flag_we=1, zero_in=1 -> every rd_addr reads 8'h00 and zero_flag=0 after release.
2. Write/read all:
   - Write mem[i] = 8'h10+i for i=0..7 on consecutive cycles, then sweep rd_addrA=0..7 and rd_addrB=7..0.
   - Required: datA_out = 8'h10+i, datB_out = 8'h17-i, every location distinct, no aliasing.
3. Bypass:
   - Setup: mem[5]=8'h33; drive wr_en=1, wr_addr=5, dat_in=8'hC4, rd_addrA=rd_addrB=5.
   - BYPASS=1: both ports show 8'hC4 before the edge.
   - BYPASS=0: both ports show 8'h33 before the edge and 8'hC4 after.
4. Flag capture:
   - flag_we=1, zero_in=1 -> zero_flag=1 next cycle.
   - Then flag_we=0, zero_in=0 for 3 cycles -> zero_flag stays 1.
   - Then flag_we=1, zero_in=0 -> zero_flag=0.
5. Simultaneous events:
   - Same edge: wr_en=1, wr_addr=2, dat_in=8'h00, flag_we=1, zero_in=1 -> mem[2]=8'h00 and zero_flag=1 both updated.
   - Next edge with reset=1 plus wr_en=1, wr_addr=2, dat_in=8'hFF -> mem[2]=8'h00 and zero_flag=0.
6. ALU loop: connect to the ALU; preload r1=8'h01, r2=8'h02; issue XOR (ALU_Op=2'b11) r1,r1 -> r3.
   - r3=8'h00 and zero_flag=1.
   - Then increment r2 -> r2=8'h03 and zero_flag=0.
